// File: rtl/gate3_tt_if.sv
// Board-side signal bundle for the 3-input gate truth-table sequencer.
// The master drives start/abort and the gate output; the slave (sequencer) drives the rest.
interface gate3_tt_if;
  logic       start;
  logic       abort;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic [2:0] idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_out;
  logic [7:0] err_mask;

  modport master (
    output start, abort, y_in,
    input  a_out, b_out, c_out, idx, busy, done, pass, table_out, err_mask
  );

  modport slave (
    input  start, abort, y_in,
    output a_out, b_out, c_out, idx, busy, done, pass, table_out, err_mask
  );
endinterface

// File: rtl/gate3_tt_sequencer.sv
// Walks a 3-input gate through all 8 input vectors, samples its output after a settle
// delay and compares the captured truth table against EXPECT.
module gate3_tt_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  EXPECT     = 8'h7F
) (
  input logic       clk,
  input logic       rst,
  gate3_tt_if.slave bus
);
  localparam int unsigned   CW       = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx_r, idx_next;
  logic          busy_r, busy_next;
  logic          done_r, done_next;
  logic          pass_r, pass_next;
  logic [7:0]    table_r, table_next;
  logic [7:0]    err_r, err_next;
  logic [7:0]    table_smp, err_smp;
  logic          sample_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      table_r <= '0;
      err_r   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx_r   <= idx_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
      pass_r  <= pass_next;
      table_r <= table_next;
      err_r   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx_r;
    busy_next  = busy_r;
    done_next  = done_r;
    pass_next  = pass_r;
    table_next = table_r;
    err_next   = err_r;

    // Table contents as they would be after this edge's sample; pass uses the final vector too.
    sample_now         = (cnt == CNT_LAST);
    table_smp          = table_r;
    table_smp[idx_r]   = bus.y_in;
    err_smp            = err_r;
    err_smp[idx_r]     = bus.y_in ^ EXPECT[idx_r];

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = RUN;
          idx_next   = '0;
          cnt_next   = '0;
          table_next = '0;
          err_next   = '0;
          pass_next  = 1'b0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b0;
          pass_next  = 1'b0;
        end else if (sample_now) begin
          table_next = table_smp;
          err_next   = err_smp;
          cnt_next   = '0;
          if (idx_r == 3'd7) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            pass_next  = (err_smp == '0);
          end else begin
            idx_next = idx_r + 3'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
          done_next  = 1'b0;
          pass_next  = 1'b0;
        end else if (bus.start) begin
          state_next = RUN;
          idx_next   = '0;
          cnt_next   = '0;
          table_next = '0;
          err_next   = '0;
          pass_next  = 1'b0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.a_out     = idx_r[2];
  assign bus.b_out     = idx_r[1];
  assign bus.c_out     = idx_r[0];
  assign bus.idx       = idx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.table_out = table_r;
  assign bus.err_mask  = err_r;
endmodule

// File: tb/tb_gate3_tt_sequencer.sv
// Directed bench for gate3_tt_sequencer: a NAND3/stuck-at model on one instance,
// an AND3 model with EXPECT=8'h80 and single-cycle settle on a second.
module tb_gate3_tt_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  gate3_tt_if bus0();
  gate3_tt_if bus1();

  // Gate under test models: mode 0 = NAND3, mode 1 = output stuck at 1.
  assign bus0.y_in = (mode == 2'd1) ? 1'b1 : ~(bus0.a_out & bus0.b_out & bus0.c_out);
  assign bus1.y_in = bus1.a_out & bus1.b_out & bus1.c_out;

  gate3_tt_sequencer #(.SETTLE_CYC(2), .EXPECT(8'h7F)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  gate3_tt_sequencer #(.SETTLE_CYC(1), .EXPECT(8'h80)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start0();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
  endtask

  task automatic wait_done0(output int edges);
    edges = 0;
    while (bus0.done !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    bus0.start = 1'b1; bus0.abort = 1'b0;
    bus1.start = 1'b1; bus1.abort = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus0.busy, bus0.done, bus0.pass} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got %b exp 000", {bus0.busy, bus0.done, bus0.pass}); end
    checks++;
    if ({bus0.idx, bus0.a_out, bus0.b_out, bus0.c_out} !== 6'd0)
      begin errors++; $display("FAIL reset_idx got idx=%0d abc=%b exp 0/000", bus0.idx, {bus0.a_out, bus0.b_out, bus0.c_out}); end
    checks++;
    if (bus0.table_out !== 8'h00 || bus0.err_mask !== 8'h00)
      begin errors++; $display("FAIL reset_table got %h/%h exp 00/00", bus0.table_out, bus0.err_mask); end
    checks++;
    if ({bus1.busy, bus1.done, bus1.table_out} !== 10'd0)
      begin errors++; $display("FAIL reset_dut1 got %b exp 0", {bus1.busy, bus1.done, bus1.table_out}); end
    rst = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    tick();
    checks++;
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0)
      begin errors++; $display("FAIL reset_idle got busy=%b%b exp 00", bus0.busy, bus1.busy); end
  endtask

  task automatic test_nand_run();
    int bad = 0;
    mode = 2'd0;
    pulse_start0();
    checks++;
    if (bus0.busy !== 1'b1 || bus0.idx !== 3'd0 || bus0.done !== 1'b0)
      begin errors++; $display("FAIL nand_accept got busy=%b idx=%0d done=%b exp 1/0/0", bus0.busy, bus0.idx, bus0.done); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16 && (bus0.idx !== 3'(k / 2) || bus0.busy !== 1'b1 || bus0.done !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0)
      begin errors++; $display("FAIL nand_sequence got %0d bad cycles exp 0", bad); end
    checks++;
    if (bus0.done !== 1'b1 || bus0.busy !== 1'b0)
      begin errors++; $display("FAIL nand_done_edge16 got done=%b busy=%b exp 1/0", bus0.done, bus0.busy); end
    checks++;
    if (bus0.table_out !== 8'h7F || bus0.err_mask !== 8'h00 || bus0.pass !== 1'b1)
      begin errors++; $display("FAIL nand_result got %h/%h pass=%b exp 7f/00/1", bus0.table_out, bus0.err_mask, bus0.pass); end
    tick(); tick(); tick();
    checks++;
    if (bus0.done !== 1'b1 || bus0.idx !== 3'd7 || {bus0.a_out, bus0.b_out, bus0.c_out} !== 3'b111 || bus0.table_out !== 8'h7F)
      begin errors++; $display("FAIL done_hold got done=%b idx=%0d table=%h exp 1/7/7f", bus0.done, bus0.idx, bus0.table_out); end
  endtask

  task automatic test_stuck_high();
    int e;
    mode = 2'd1;
    pulse_start0();
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b1 || bus0.idx !== 3'd0 || bus0.table_out !== 8'h00 || bus0.err_mask !== 8'h00)
      begin errors++; $display("FAIL restart_from_done got done=%b busy=%b idx=%0d table=%h exp 0/1/0/00", bus0.done, bus0.busy, bus0.idx, bus0.table_out); end
    wait_done0(e);
    checks++;
    if (e != 16)
      begin errors++; $display("FAIL stuck_latency got %0d exp 16", e); end
    checks++;
    if (bus0.table_out !== 8'hFF || bus0.err_mask !== 8'h80 || bus0.pass !== 1'b0)
      begin errors++; $display("FAIL stuck_result got %h/%h pass=%b exp ff/80/0", bus0.table_out, bus0.err_mask, bus0.pass); end
  endtask

  task automatic test_abort();
    int n;
    int e;
    mode = 2'd0;
    bus0.start = 1'b1; bus0.abort = 1'b1;
    tick();
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.pass !== 1'b0 || bus0.table_out !== 8'hFF || bus0.err_mask !== 8'h80)
      begin errors++; $display("FAIL done_abort got done=%b busy=%b table=%h err=%h exp 0/0/ff/80", bus0.done, bus0.busy, bus0.table_out, bus0.err_mask); end
    tick();
    checks++;
    if (bus0.busy !== 1'b0)
      begin errors++; $display("FAIL idle_abort_priority got busy=%b exp 0", bus0.busy); end
    bus0.start = 1'b0; bus0.abort = 1'b0;
    pulse_start0();
    n = 0;
    while (bus0.idx !== 3'd3 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 6)
      begin errors++; $display("FAIL reach_idx3 got %0d edges exp 6", n); end
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0 || {bus0.a_out, bus0.b_out, bus0.c_out} !== 3'b000 || bus0.idx !== 3'd0)
      begin errors++; $display("FAIL run_abort got busy=%b done=%b abc=%b exp 0/0/000", bus0.busy, bus0.done, {bus0.a_out, bus0.b_out, bus0.c_out}); end
    checks++;
    if (bus0.table_out !== 8'h07 || bus0.err_mask !== 8'h00)
      begin errors++; $display("FAIL abort_partial got %h/%h exp 07/00", bus0.table_out, bus0.err_mask); end
    tick(); tick();
    checks++;
    if (bus0.busy !== 1'b0 || bus0.table_out !== 8'h07)
      begin errors++; $display("FAIL abort_stays_idle got busy=%b table=%h exp 0/07", bus0.busy, bus0.table_out); end
    pulse_start0();
    wait_done0(e);
    checks++;
    if (e != 16 || bus0.table_out !== 8'h7F || bus0.pass !== 1'b1)
      begin errors++; $display("FAIL after_abort_run got edges=%0d table=%h pass=%b exp 16/7f/1", e, bus0.table_out, bus0.pass); end
  endtask

  task automatic test_back_to_back();
    int e;
    pulse_start0();
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b1 || bus0.idx !== 3'd0)
      begin errors++; $display("FAIL b2b_restart got done=%b busy=%b idx=%0d exp 0/1/0", bus0.done, bus0.busy, bus0.idx); end
    e = 0;
    while (bus0.done !== 1'b1 && e < 200) begin
      bus0.start = (e == 3 || e == 9 || e == 10);
      tick();
      e++;
    end
    bus0.start = 1'b0;
    checks++;
    if (e != 16)
      begin errors++; $display("FAIL b2b_latency got %0d exp 16", e); end
    checks++;
    if (bus0.table_out !== 8'h7F || bus0.err_mask !== 8'h00 || bus0.pass !== 1'b1)
      begin errors++; $display("FAIL b2b_result got %h/%h pass=%b exp 7f/00/1", bus0.table_out, bus0.err_mask, bus0.pass); end
  endtask

  task automatic test_and_single_settle();
    int e;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    checks++;
    if (bus1.busy !== 1'b1 || bus1.idx !== 3'd0)
      begin errors++; $display("FAIL and_accept got busy=%b idx=%0d exp 1/0", bus1.busy, bus1.idx); end
    e = 0;
    while (bus1.done !== 1'b1 && e < 200) begin
      tick();
      e++;
    end
    checks++;
    if (e != 8)
      begin errors++; $display("FAIL and_latency got %0d exp 8", e); end
    checks++;
    if (bus1.table_out !== 8'h80 || bus1.err_mask !== 8'h00 || bus1.pass !== 1'b1)
      begin errors++; $display("FAIL and_result got %h/%h pass=%b exp 80/00/1", bus1.table_out, bus1.err_mask, bus1.pass); end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    test_reset();
    test_nand_run();
    test_stuck_high();
    test_abort();
    test_back_to_back();
    test_and_single_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
